// File: rtl/ofdm_frame_scheduler.sv
// ofdm_frame_scheduler: TX frame phase sequencer (clear, training, SIGNAL, data, gap)
// with a per-phase watchdog and abort/error recovery; all outputs registered.
module ofdm_frame_scheduler #(
  parameter int CLR_CYC = 2,
  parameter int GAP_CYC = 16,
  parameter int TMO_W   = 12,
  parameter int TMO_CYC = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_req,
  input  logic [7:0] frame_nsym,
  input  logic       abort,
  output logic       tx_clr,
  output logic       train_start,
  input  logic       train_done,
  output logic       sig_start,
  input  logic       sig_done,
  output logic       data_start,
  input  logic       data_done,
  output logic [7:0] sym_cnt,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_TRAIN = 3'd2;
  localparam logic [2:0] S_SIG   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_RECOV = 3'd6;
  localparam int CW = $clog2(CLR_CYC + GAP_CYC + 1);

  logic [2:0]       r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [TMO_W-1:0] r_wdog, w_wdog;
  logic [7:0]       r_nsym, w_nsym, r_sym_cnt, w_sym_cnt;
  logic             w_tmo, w_err, w_dstart, w_enter;
  logic             r_tx_clr, r_train_start, r_sig_start, r_data_start;
  logic             r_busy, r_frame_done, r_frame_err;

  always_comb begin
    w_state   = r_state;
    w_nsym    = r_nsym;
    w_sym_cnt = r_sym_cnt;
    w_err     = 1'b0;
    w_dstart  = 1'b0;
    w_tmo     = r_wdog == TMO_W'(TMO_CYC - 1);
    case (r_state)
      S_IDLE:
        if (frame_req) begin
          w_state   = S_CLR;
          w_nsym    = frame_nsym;
          w_sym_cnt = '0;
        end
      S_CLR:
        if (abort) w_state = S_RECOV;
        else if (r_cnt == CW'(CLR_CYC - 1)) w_state = S_TRAIN;
      S_TRAIN:
        if (abort) w_state = S_RECOV;
        else if (train_done) w_state = S_SIG;
        else if (w_tmo) begin
          w_state = S_RECOV;
          w_err   = 1'b1;
        end
      S_SIG:
        if (abort) w_state = S_RECOV;
        else if (sig_done) w_state = (r_nsym == '0) ? S_GAP : S_DATA;
        else if (w_tmo) begin
          w_state = S_RECOV;
          w_err   = 1'b1;
        end
      S_DATA:
        if (abort) w_state = S_RECOV;
        else if (data_done) begin
          w_sym_cnt = r_sym_cnt + 8'd1;
          if (w_sym_cnt == r_nsym) w_state = S_GAP;
          else w_dstart = 1'b1;
        end else if (w_tmo) begin
          w_state = S_RECOV;
          w_err   = 1'b1;
        end
      S_GAP:
        if (r_cnt == CW'(GAP_CYC - 1)) w_state = S_IDLE;
      S_RECOV:
        if (r_cnt == CW'(CLR_CYC + GAP_CYC - 1)) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_enter = w_state != r_state;
    w_cnt   = w_enter ? '0 : r_cnt + 1'b1;
    // watchdog restarts on every phase entry and every data_start
    w_wdog  = (!w_enter && !w_dstart && (r_state == S_TRAIN || r_state == S_SIG || r_state == S_DATA))
              ? r_wdog + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_wdog        <= '0;
      r_nsym        <= '0;
      r_sym_cnt     <= '0;
      r_tx_clr      <= 1'b0;
      r_train_start <= 1'b0;
      r_sig_start   <= 1'b0;
      r_data_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_wdog        <= w_wdog;
      r_nsym        <= w_nsym;
      r_sym_cnt     <= w_sym_cnt;
      r_tx_clr      <= w_state == S_CLR || (w_state == S_RECOV && w_cnt < CW'(CLR_CYC));
      r_train_start <= w_enter && w_state == S_TRAIN;
      r_sig_start   <= w_enter && w_state == S_SIG;
      r_data_start  <= w_state == S_DATA && (w_enter || w_dstart);
      r_busy        <= w_state != S_IDLE;
      r_frame_done  <= w_enter && w_state == S_GAP;
      r_frame_err   <= w_err;
    end
  end

  assign tx_clr      = r_tx_clr;
  assign train_start = r_train_start;
  assign sig_start   = r_sig_start;
  assign data_start  = r_data_start;
  assign sym_cnt     = r_sym_cnt;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
// tb_ofdm_frame_scheduler: per-cycle comparison against a timeline model built from
// phase latencies; the bench plays the training/SIGNAL/data peripherals.
module tb_ofdm_frame_scheduler;
  localparam int CLR = 2, GAP = 16, TMO = 100, MAXC = 400;

  logic clk = 0, rst = 1, frame_req = 0, abort = 0;
  logic train_done = 0, sig_done = 0, data_done = 0;
  logic [7:0] frame_nsym = 0;
  logic tx_clr, train_start, sig_start, data_start, busy, frame_done, frame_err;
  logic [7:0] sym_cnt;

  always #5 clk = ~clk;

  ofdm_frame_scheduler #(.CLR_CYC(CLR), .GAP_CYC(GAP), .TMO_W(12), .TMO_CYC(TMO)) u_dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .frame_nsym(frame_nsym), .abort(abort),
    .tx_clr(tx_clr), .train_start(train_start), .train_done(train_done),
    .sig_start(sig_start), .sig_done(sig_done), .data_start(data_start),
    .data_done(data_done), .sym_cnt(sym_cnt), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  int n_run = 0, n_fail = 0;
  // expected outputs: 0 tx_clr,1 train_start,2 sig_start,3 data_start,4 frame_done,5 frame_err,6 busy
  logic [6:0] e_out[MAXC];
  int         e_sym[MAXC];
  // stimulus: 0 req,1 abort,2 train_done,3 sig_done,4 data_done
  logic [4:0] s_in[MAXC];
  logic [7:0] s_nsym[MAXC];
  int g_lat[$];
  int g_ss, g_ds0, g_dd0, g_dd1, g_fd;

  function automatic logic [6:0] obs();
    return {busy, frame_err, frame_done, data_start, sig_start, train_start, tx_clr};
  endfunction

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      e_out[c] = '0; e_sym[c] = 0; s_in[c] = '0; s_nsym[c] = 8'($urandom);
    end
  endtask

  task automatic mark(input int c, input int b);
    if (c < MAXC) e_out[c][b] = 1'b1;
  endtask

  task automatic put(input int c, input int b, input int ab);
    if (c < MAXC && (ab < 0 || c <= ab)) s_in[c][b] = 1'b1;
  endtask

  task automatic recover(input int f, input bit err, output int idle_at);
    for (int c = f; c < MAXC; c++) begin e_out[c] = '0; e_sym[c] = e_sym[f-1]; end
    for (int c = f; c < f + CLR; c++) mark(c, 0);
    for (int c = f; c < f + CLR + GAP; c++) mark(c, 6);
    if (err) mark(f, 5);
    idle_at = f + CLR + GAP;
  endtask

  // one frame requested in cycle r; g_lat = {train, sig, data0, data1, ...} latencies from start to done
  task automatic model(input int r, input int n, input int ab, input bit hold, output int idle_at);
    int t, dd;
    s_in[r][0] = 1'b1;
    s_nsym[r] = 8'(n);
    for (int c = r + 1; c < MAXC; c++) begin e_sym[c] = 0; mark(c, 6); end
    for (int c = r + 1; c <= r + CLR; c++) mark(c, 0);
    t = r + CLR + 1;
    mark(t, 1);
    if (hold) begin recover(t + TMO, 1'b1, idle_at); return; end
    t = t + g_lat[0]; put(t, 2, ab); t++;
    mark(t, 2); g_ss = t;
    t = t + g_lat[1]; put(t, 3, ab); t++;
    g_ds0 = t;
    for (int i = 0; i < n; i++) begin
      mark(t, 3);
      dd = t + g_lat[2+i];
      put(dd, 4, ab);
      if (i == 0) g_dd0 = dd;
      if (i == 1) g_dd1 = dd;
      for (int c = dd + 1; c < MAXC; c++) e_sym[c] = i + 1;
      t = dd + 1;
    end
    mark(t, 4); g_fd = t;
    idle_at = t + GAP;
    for (int c = idle_at; c < MAXC; c++) e_out[c][6] = 1'b0;
    if (ab >= 0) recover(ab + 1, 1'b0, idle_at);
  endtask

  task automatic rand_lat(input int n, input int lo);
    g_lat = {};
    g_lat.push_back($urandom_range(1, 20));
    g_lat.push_back($urandom_range(lo, 12));
    for (int i = 0; i < n; i++) g_lat.push_back($urandom_range(1, 12));
  endtask

  task automatic do_reset();
    {data_done, sig_done, train_done, abort, frame_req} = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      n_run++;
      if ({obs(), sym_cnt} !== {e_out[c], 8'(e_sym[c])}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got out=%b sym=%0d, expected out=%b sym=%0d",
                 name, c, obs(), sym_cnt, e_out[c], e_sym[c]);
      end
      {data_done, sig_done, train_done, abort, frame_req} = s_in[c];
      frame_nsym = s_nsym[c];
      @(posedge clk); #1;
    end
    {data_done, sig_done, train_done, abort, frame_req} = '0;
  endtask

  task automatic test_reset();
    int idle;
    #2;
    {data_done, sig_done, train_done, abort, frame_req} = '1;
    rst = 1;
    #1;
    n_run++;
    if ({obs(), sym_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async: got out=%b sym=%0d, expected 0", obs(), sym_cnt);
    end
    do_reset();
    clear_plan();
    for (int c = 0; c < 12; c++) s_in[c] = 5'($urandom) & 5'b11110;
    run(14, "idle_stray");
    idle = 0;
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b, expected 0", busy);
    end
    if (idle != 0) n_fail++;
  endtask

  task automatic test_normal();
    int idle;
    do_reset(); clear_plan();
    g_lat = {17, 9, 9, 9, 9};
    model(0, 3, -1, 1'b0, idle);
    s_in[g_fd + 3][1] = 1'b1;
    run(idle + 3, "normal_plan");
    for (int k = 0; k < 3; k++) begin
      int n = $urandom_range(1, 6);
      do_reset(); clear_plan();
      rand_lat(n, 1);
      model(0, n, -1, 1'b0, idle);
      run(idle + 3, "normal_rand");
    end
  endtask

  task automatic test_nsym0();
    int idle;
    do_reset(); clear_plan();
    rand_lat(0, 1);
    model(0, 0, -1, 1'b0, idle);
    run(idle + 3, "nsym0");
  endtask

  task automatic test_watchdog();
    int idle;
    do_reset(); clear_plan();
    rand_lat(2, 1);
    model(0, 2, -1, 1'b1, idle);
    run(idle + 3, "watchdog");
  endtask

  task automatic test_abort();
    int idle, ab;
    do_reset(); clear_plan();
    rand_lat(3, 1);
    g_lat[3] = $urandom_range(2, 12);
    model(0, 3, -1, 1'b0, idle);
    ab = g_dd0 + 1 + $urandom_range(0, g_lat[3] - 1);
    clear_plan();
    model(0, 3, ab, 1'b0, idle);
    s_in[ab][1] = 1'b1;
    s_in[ab + 3][1] = 1'b1;
    run(idle + 3, "abort_data");
    do_reset(); clear_plan();
    rand_lat(3, 1);
    model(0, 3, -1, 1'b0, idle);
    ab = g_dd1;
    clear_plan();
    model(0, 3, ab, 1'b0, idle);
    s_in[ab][1] = 1'b1;
    run(idle + 3, "abort_with_done");
  endtask

  task automatic test_back_to_back();
    int idle1, idle2, n1, n2;
    do_reset(); clear_plan();
    n1 = $urandom_range(1, 4);
    rand_lat(n1, 1);
    model(0, n1, -1, 1'b0, idle1);
    s_in[g_ds0][0] = 1'b1;
    s_in[g_fd + 2][0] = 1'b1;
    s_in[idle1 - 1][0] = 1'b1;
    n2 = $urandom_range(0, 4);
    rand_lat(n2, 1);
    model(idle1, n2, -1, 1'b0, idle2);
    run(idle2 + 3, "back_to_back");
  endtask

  task automatic test_reset_mid();
    int idle;
    do_reset(); clear_plan();
    rand_lat(2, 5);
    model(0, 2, -1, 1'b0, idle);
    run(g_ss + 2, "pre_mid_reset");
    #2 rst = 1;
    #1;
    n_run++;
    if ({obs(), sym_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got out=%b sym=%0d, expected 0", obs(), sym_cnt);
    end
    @(posedge clk);
    #1 rst = 0;
    clear_plan();
    s_in[1][3] = 1'b1;
    s_in[2][2] = 1'b1;
    rand_lat(2, 1);
    model(4, 2, -1, 1'b0, idle);
    run(idle + 3, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_nsym0();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
